// File: rtl/tpu_job_seq_if.sv
// Host-side signal bundle for tpu_job_seq: job control, input/output streams
// and the tpuv1 memory-mapped bus. The slave modport is the sequencer's view.
interface tpu_job_seq_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             start;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic             bus_rw;
    logic [ADDRW-1:0] bus_addr;
    logic [DATAW-1:0] bus_wdata;
    logic [DATAW-1:0] bus_rdata;

    modport master (
        output start, in_valid, in_data, out_ready, bus_rdata,
        input  busy, done, in_ready, out_valid, out_data, bus_rw, bus_addr, bus_wdata
    );

    modport slave (
        input  start, in_valid, in_data, out_ready, bus_rdata,
        output busy, done, in_ready, out_valid, out_data, bus_rw, bus_addr, bus_wdata
    );
endinterface

// File: rtl/tpu_job_seq.sv
// Job sequencer for the tpuv1 matrix unit: streams A/B (and C) into tpuv1,
// starts it, waits the compute window and streams C back out.
// TPU_SEQ_CPRELOAD_EN: take C preload words from the input stream instead of zero-filling.
module tpu_job_seq #(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int DATAW = 64
) (
    input  logic         clk,
    input  logic         rst,
    tpu_job_seq_if.slave io
);
    localparam int ROW_W = $clog2(DIM);
    localparam int IDX_W = $clog2(2*DIM);
    localparam int CNT_W = $clog2(3*DIM+1) + 1;

    localparam logic [ADDRW-1:0] A_BASE = ADDRW'(32'h0100);
    localparam logic [ADDRW-1:0] B_BASE = ADDRW'(32'h0200);
    localparam logic [ADDRW-1:0] C_BASE = ADDRW'(32'h0300);
    localparam logic [ADDRW-1:0] GO_ADR = ADDRW'(32'h0400);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_START, S_COMPUTE, S_READ, S_DONE
    } state_t;

    state_t           state, state_n;
    logic [ROW_W-1:0] row, row_n;
    logic             half, half_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             rd_all, rd_all_n;
    logic             rw_q, rw_n;
    logic [ADDRW-1:0] addr_q, addr_n;
    logic [DATAW-1:0] wdata_q, wdata_n;
    logic             ov_q, ov_n;
    logic [DATAW-1:0] od_q, od_n;

    logic             c_go;
    logic             c_in;
    logic [DATAW-1:0] c_data;

`ifdef TPU_SEQ_CPRELOAD_EN
    assign c_go   = io.in_valid;
    assign c_in   = 1'b1;
    assign c_data = io.in_data;
`else
    assign c_go   = 1'b1;
    assign c_in   = 1'b0;
    assign c_data = '0;
`endif

    wire row_last = (row == ROW_W'(DIM-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            half    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            rd_all  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            half    <= half_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            rd_all  <= rd_all_n;
            rw_q    <= rw_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            ov_q    <= ov_n;
            od_q    <= od_n;
        end
    end

    always_comb begin
        state_n  = state;
        row_n    = row;
        half_n   = half;
        cnt_n    = cnt;
        idx_n    = idx;
        rd_all_n = rd_all;
        rw_n     = 1'b0;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        ov_n     = ov_q;
        od_n     = od_q;
        unique case (state)
            S_IDLE: begin
                if (io.start) begin
                    state_n = S_LOAD_A;
                    row_n   = '0;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (io.in_valid) begin
                    rw_n    = 1'b1;
                    addr_n  = ((state == S_LOAD_A) ? A_BASE : B_BASE) + (ADDRW'(row) << 3);
                    wdata_n = io.in_data;
                    row_n   = row_last ? '0 : row + ROW_W'(1);
                    if (row_last) begin
                        state_n = (state == S_LOAD_A) ? S_LOAD_B : S_LOAD_C;
                        half_n  = 1'b0;
                    end
                end
            end
            S_LOAD_C: begin
                // Low half first; the high-half write commits the row inside tpuv1.
                if (c_go) begin
                    rw_n    = 1'b1;
                    addr_n  = C_BASE + (ADDRW'(row) << 4) + (ADDRW'(half) << 3);
                    wdata_n = c_data;
                    half_n  = ~half;
                    if (half) begin
                        row_n = row_last ? '0 : row + ROW_W'(1);
                        if (row_last) state_n = S_START;
                    end
                end
            end
            S_START: begin
                rw_n    = 1'b1;
                addr_n  = GO_ADR;
                wdata_n = '0;
                cnt_n   = '0;
                state_n = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (cnt == CNT_W'(3*DIM)) begin
                    state_n  = S_READ;
                    idx_n    = '0;
                    rd_all_n = 1'b0;
                    addr_n   = C_BASE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                // bus_addr always points at the next word to capture; it only
                // advances when the output register can take that word.
                if (rd_all) begin
                    if (io.out_ready) begin
                        ov_n    = 1'b0;
                        state_n = S_DONE;
                    end
                end else if (!ov_q || io.out_ready) begin
                    ov_n = 1'b1;
                    od_n = io.bus_rdata;
                    if (idx == IDX_W'(2*DIM-1)) begin
                        rd_all_n = 1'b1;
                    end else begin
                        idx_n  = idx + IDX_W'(1);
                        addr_n = C_BASE + ((ADDRW'(idx) + ADDRW'(1)) << 3);
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign io.busy      = (state != S_IDLE) && (state != S_DONE);
    assign io.done      = (state == S_DONE);
    assign io.in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B) || (c_in && state == S_LOAD_C);
    assign io.out_valid = ov_q;
    assign io.out_data  = od_q;
    assign io.bus_rw    = rw_q;
    assign io.bus_addr  = addr_q;
    assign io.bus_wdata = wdata_q;
endmodule
